// File: rtl/display_scan_ctrl.sv
// Multiplexed display scan controller.
// Steps through DIGITS digit slots of 2^DIV_W clocks each. Every slot opens with
// BLANK_CYCLES of anti-ghost blanking. New digit data is staged with `update`
// and becomes active only at a frame boundary, so a frame never mixes old and
// new data. Every output is registered and lags the internal scan by one cycle.
// Optional feature: define LEADING_ZERO_BLANK_EN to keep leading zero digits dark.
module display_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int DIV_W        = 17,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   hexs,
    input  logic [DIGITS-1:0]     points,
    input  logic [DIGITS-1:0]     LEs,
    input  logic                  update,
    output logic [DIGITS-1:0]     AN,
    output logic [3:0]            HEX,
    output logic                  point,
    output logic                  LE,
    output logic                  frame_done
);

    localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned HEX_W    = 4 * DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W:0]   BLANK_LIM = (DIV_W + 1)'(BLANK_CYCLES);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam state_t RST_STATE = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    // Scan position and frame data
    state_t              state, stateNext;
    logic [DIV_W-1:0]    slotCnt, slotNext;
    logic [IDX_W-1:0]    idx, idxNext;
    logic                wrapped, boundary;
    logic [HEX_W-1:0]    stagingHex, stagingHexNext, activeHex, activeHexNext;
    logic [DIGITS-1:0]   stagingPts, stagingPtsNext, activePts, activePtsNext;
    logic [DIGITS-1:0]   stagingLe, stagingLeNext, activeLe, activeLeNext;
    logic                pending, pendingNext;

    // Next values for the registered outputs
    logic [DIGITS-1:0]   anNext;
    logic [3:0]          hexNext;
    logic                pointNext, leNext;
    logic [DIGITS-1:0]   suppress;

    // Leading-zero suppression mask taken from the active frame data
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic zeroAbove;
        suppress  = '0;
        zeroAbove = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zeroAbove   = zeroAbove && (activeHex[4*k +: 4] == 4'h0) && !activePts[k];
            suppress[k] = zeroAbove;
        end
    end
`else
    always_comb begin
        suppress = '0;
    end
`endif

    // Next state: slot/digit counters, BLANK/SHOW phase, staging and frame swap, outputs
    always_comb begin
        slotNext       = slotCnt + DIV_W'(1);
        idxNext        = idx;
        boundary       = 1'b0;
        stateNext      = state;
        stagingHexNext = stagingHex;
        stagingPtsNext = stagingPts;
        stagingLeNext  = stagingLe;
        activeHexNext  = activeHex;
        activePtsNext  = activePts;
        activeLeNext   = activeLe;
        pendingNext    = pending;
        anNext         = '1;
        hexNext        = activeHex[{idx, 2'b00} +: 4];
        pointNext      = activePts[idx];
        leNext         = activeLe[idx];

        if (slotCnt == '1) begin
            if (idx == LAST_IDX) begin
                idxNext  = '0;
                boundary = 1'b1;
            end else begin
                idxNext = idx + IDX_W'(1);
            end
        end

        stateNext = ({1'b0, slotNext} < BLANK_LIM) ? BLANK : SHOW;

        if (update) begin
            stagingHexNext = hexs;
            stagingPtsNext = points;
            stagingLeNext  = LEs;
            pendingNext    = 1'b1;
        end

        // Frame swap; an update landing on the boundary bypasses staging
        if (boundary) begin
            pendingNext = 1'b0;
            if (update) begin
                activeHexNext = hexs;
                activePtsNext = points;
                activeLeNext  = LEs;
            end else if (pending) begin
                activeHexNext = stagingHex;
                activePtsNext = stagingPts;
                activeLeNext  = stagingLe;
            end
        end

        if (state == SHOW && activeLe[idx] && !suppress[idx]) begin
            anNext[idx] = 1'b0;
        end
    end

    // State, data and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST_STATE;
            slotCnt    <= '0;
            idx        <= '0;
            wrapped    <= 1'b0;
            stagingHex <= '0;
            stagingPts <= '0;
            stagingLe  <= '0;
            activeHex  <= '0;
            activePts  <= '0;
            activeLe   <= '0;
            pending    <= 1'b0;
            AN         <= '1;
            HEX        <= 4'h0;
            point      <= 1'b0;
            LE         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= stateNext;
            slotCnt    <= slotNext;
            idx        <= idxNext;
            wrapped    <= boundary;
            stagingHex <= stagingHexNext;
            stagingPts <= stagingPtsNext;
            stagingLe  <= stagingLeNext;
            activeHex  <= activeHexNext;
            activePts  <= activePtsNext;
            activeLe   <= activeLeNext;
            pending    <= pendingNext;
            AN         <= anNext;
            HEX        <= hexNext;
            point      <= pointNext;
            LE         <= leNext;
            frame_done <= wrapped;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIGITS=4, DIV_W=4, BLANK_CYCLES=2.
// Output index c counts output cycles since reset release. Output c shows slot c%16
// of digit (c/16)%4, and frame_done pulses when c%64==0 and c>0.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] hexs = 16'h0;
    logic [3:0]  points = 4'h0;
    logic [3:0]  LEs = 4'h0;
    logic        update = 1'b0;
    logic [3:0]  AN;
    logic [3:0]  HEX;
    logic        point, LE, frame_done;

    int nCmp = 0;
    int nErr = 0;
    int c = -1;

    // Data the bench expects on screen, plus the data it expects to be staged
    logic [15:0] shHex = 16'h0, stHex = 16'h0;
    logic [3:0]  shPts = 4'h0, stPts = 4'h0, shLe = 4'h0, stLe = 4'h0;
    bit          pend = 1'b0;

    display_scan_ctrl #(.DIGITS(4), .DIV_W(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .hexs(hexs), .points(points), .LEs(LEs),
        .update(update), .AN(AN), .HEX(HEX), .point(point), .LE(LE),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Expected {AN, HEX, point, LE, frame_done} for output index cc
    function automatic logic [10:0] expOut(int cc);
        int slot, d;
        logic [3:0] an;
        slot = cc % 16;
        d    = (cc / 16) % 4;
        an   = 4'hF;
        if (slot >= 2 && shLe[d] == 1'b1) an[d] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (shHex >> (4 * d)) == 16'h0 && (shPts >> d) == 4'h0) an = 4'hF;
`endif
        return {an, shHex[4*d +: 4], shPts[d], shLe[d], (cc > 0 && cc % 64 == 0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        c++;
        if (c > 0 && c % 64 == 0 && pend) begin
            shHex = stHex; shPts = stPts; shLe = stLe;
            pend  = 1'b0;
        end
    endtask

    task automatic pulseUpdate(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
        hexs = h; points = p; LEs = l; update = 1'b1;
        stHex = h; stPts = p; stLe = l; pend = 1'b1;
        step();
        update = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nCmp++;
        if ({AN, HEX, point, LE, frame_done} !== {4'hF, 4'h0, 3'b000}) begin
            nErr++;
            $display("FAIL reset_hold got=%h exp=%h", {AN, HEX, point, LE, frame_done}, {4'hF, 4'h0, 3'b000});
        end
        rst = 1'b0;
        c = -1;
        step();
        nCmp++;
        if ({AN, HEX, point, LE, frame_done} !== {4'hF, 4'h0, 3'b000}) begin
            nErr++;
            $display("FAIL reset_first got=%h exp=%h", {AN, HEX, point, LE, frame_done}, {4'hF, 4'h0, 3'b000});
        end
    endtask

    task automatic test_idle();
        int pulses = 0;
        while (c < 199) begin
            step();
            if (frame_done === 1'b1) pulses++;
            nCmp++;
            if ({AN, HEX, point, LE, frame_done} !== expOut(c)) begin
                nErr++;
                $display("FAIL idle c=%0d got=%h exp=%h", c, {AN, HEX, point, LE, frame_done}, expOut(c));
            end
        end
        nCmp++;
        if (pulses != 3) begin
            nErr++;
            $display("FAIL idle_frame_count got=%0d exp=3", pulses);
        end
    endtask

    task automatic test_update();
        pulseUpdate(16'h1234, 4'h0, 4'hF);
        while (c < 319) begin
            step();
            nCmp++;
            if ({AN, HEX, point, LE, frame_done} !== expOut(c)) begin
                nErr++;
                $display("FAIL update c=%0d got=%h exp=%h", c, {AN, HEX, point, LE, frame_done}, expOut(c));
            end
            if (c == 255 || c == 256 || c == 258 || c == 309) begin
                logic [8:0] want;
                case (c)
                    255:     want = {4'hF, 4'h0, 1'b0};
                    256:     want = {4'hF, 4'h4, 1'b1};
                    258:     want = {4'hE, 4'h4, 1'b0};
                    default: want = {4'h7, 4'h1, 1'b0};
                endcase
                nCmp++;
                if ({AN, HEX, frame_done} !== want) begin
                    nErr++;
                    $display("FAIL update_spot c=%0d got=%h exp=%h", c, {AN, HEX, frame_done}, want);
                end
            end
        end
    endtask

    task automatic test_mid_frame();
        while (c < 330) step();
        pulseUpdate(16'hABCD, 4'h0, 4'hF);
        while (c < 446) begin
            step();
            nCmp++;
            if ({AN, HEX, point, LE, frame_done} !== expOut(c)) begin
                nErr++;
                $display("FAIL midframe c=%0d got=%h exp=%h", c, {AN, HEX, point, LE, frame_done}, expOut(c));
            end
            if (c == 370 || c == 386) begin
                logic [7:0] want;
                want = (c == 370) ? {4'h7, 4'h1} : {4'hE, 4'hD};
                nCmp++;
                if ({AN, HEX} !== want) begin
                    nErr++;
                    $display("FAIL midframe_spot c=%0d got=%h exp=%h", c, {AN, HEX}, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        // c=446 is two cycles before the wrap, so this update meets the boundary edge
        pulseUpdate(16'h5678, 4'h0, 4'hF);
        while (c < 511) begin
            step();
            nCmp++;
            if ({AN, HEX, point, LE, frame_done} !== expOut(c)) begin
                nErr++;
                $display("FAIL boundary c=%0d got=%h exp=%h", c, {AN, HEX, point, LE, frame_done}, expOut(c));
            end
            if (c == 448 || c == 450) begin
                logic [8:0] want;
                want = (c == 448) ? {4'hF, 4'h8, 1'b1} : {4'hE, 4'h8, 1'b0};
                nCmp++;
                if ({AN, HEX, frame_done} !== want) begin
                    nErr++;
                    $display("FAIL boundary_spot c=%0d got=%h exp=%h", c, {AN, HEX, frame_done}, want);
                end
            end
        end
    endtask

    task automatic test_le_mask();
        int lows = 0;
        while (c < 520) step();
        pulseUpdate(16'h1234, 4'h0, 4'b1010);
        while (c < 639) begin
            step();
            if (c >= 576 && (AN[0] === 1'b0 || AN[2] === 1'b0)) lows++;
            nCmp++;
            if ({AN, HEX, point, LE, frame_done} !== expOut(c)) begin
                nErr++;
                $display("FAIL lemask c=%0d got=%h exp=%h", c, {AN, HEX, point, LE, frame_done}, expOut(c));
            end
            if (c == 610) begin
                nCmp++;
                if ({AN, HEX, LE} !== {4'hF, 4'h2, 1'b0}) begin
                    nErr++;
                    $display("FAIL lemask_spot got=%h exp=%h", {AN, HEX, LE}, {4'hF, 4'h2, 1'b0});
                end
            end
        end
        nCmp++;
        if (lows != 0) begin
            nErr++;
            $display("FAIL lemask_dark got=%0d exp=0", lows);
        end
    endtask

    task automatic test_lead_zero();
        while (c < 650) step();
        pulseUpdate(16'h0050, 4'h0, 4'hF);
        while (c < 767) begin
            step();
            nCmp++;
            if ({AN, HEX, point, LE, frame_done} !== expOut(c)) begin
                nErr++;
                $display("FAIL leadzero c=%0d got=%h exp=%h", c, {AN, HEX, point, LE, frame_done}, expOut(c));
            end
            if (c == 706 || c == 722 || c == 738 || c == 754) begin
                logic [7:0] want;
                case (c)
                    706: want = {4'hE, 4'h0};
                    722: want = {4'hD, 4'h5};
`ifdef LEADING_ZERO_BLANK_EN
                    738: want = {4'hF, 4'h0};
                    default: want = {4'hF, 4'h0};
`else
                    738: want = {4'hB, 4'h0};
                    default: want = {4'h7, 4'h0};
`endif
                endcase
                nCmp++;
                if ({AN, HEX} !== want) begin
                    nErr++;
                    $display("FAIL leadzero_spot c=%0d got=%h exp=%h", c, {AN, HEX}, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        while (c < 780) step();
        pulseUpdate(16'h9999, 4'hF, 4'hF);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nCmp++;
        if ({AN, HEX, point, LE, frame_done} !== {4'hF, 4'h0, 3'b000}) begin
            nErr++;
            $display("FAIL resetmid_hold got=%h exp=%h", {AN, HEX, point, LE, frame_done}, {4'hF, 4'h0, 3'b000});
        end
        rst = 1'b0;
        c = -1;
        shHex = 16'h0; shPts = 4'h0; shLe = 4'h0; pend = 1'b0;
        while (c < 140) begin
            step();
            nCmp++;
            if ({AN, HEX, point, LE, frame_done} !== expOut(c)) begin
                nErr++;
                $display("FAIL resetmid c=%0d got=%h exp=%h", c, {AN, HEX, point, LE, frame_done}, expOut(c));
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_update();
        test_mid_frame();
        test_back_to_back();
        test_le_mask();
        test_lead_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits, legal 2..8.
REQ-002 SHALL have parameter DIV_W, default 17, digit slot length = 2^DIV_W clk cycles, legal 3..24.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, anti-ghost blank cycles at slot start, legal 0..2^DIV_W-1.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 hexs  in  4*DIGITS  nibble k = hexs[4k+3:4k] for digit k.
REQ-008 points  in  DIGITS  decimal point bit per digit, passed through.
REQ-009 LEs  in  DIGITS  per-digit enable; 0 keeps that digit's anode off.
REQ-010 update  in  1  request to load hexs/points/LEs as next frame.
REQ-011 AN  out  DIGITS  anodes, active-low, one-hot-low or all ones.
REQ-012 HEX  out  4  nibble of current digit.
REQ-013 point  out  1  point bit of current digit.
REQ-014 LE  out  1  enable bit of current digit.
REQ-015 frame_done  out  1  one-cycle pulse at frame wrap.

Function
REQ-016 SHALL hold staging regs (hexs/points/LEs) and active regs; display uses active regs only.
REQ-017 update=1 SHALL capture inputs into staging and set pending; repeated updates overwrite staging.
REQ-018 Slot counter SHALL count 0..2^DIV_W-1 and wrap; wrap advances digit index idx 0..DIGITS-1, DIGITS-1 wraps to 0.
REQ-019 FSM states BLANK (slot count < BLANK_CYCLES) and SHOW (otherwise); BLANK_CYCLES=0 never enters BLANK.
REQ-020 In BLANK, AN SHALL be all ones; in SHOW, AN[idx]=0 iff active LE[idx]=1, others 1.
REQ-021 HEX, point, LE SHALL show active values for idx for the whole slot, including BLANK.
REQ-022 All outputs SHALL be registered: they reflect idx/state/slot-count of the preceding cycle (1-cycle latency).
REQ-023 Frame boundary = cycle idx wraps DIGITS-1 -> 0; frame_done SHALL be 1 on the output cycle digit 0's slot begins.
REQ-024 At frame boundary with pending=1, active SHALL load staging and pending SHALL clear; pending=0 leaves active unchanged.
REQ-025 update coincident with frame boundary: active SHALL load the inputs present that cycle directly; staging also loads them; pending cleared.
REQ-026 Active regs SHALL never change mid-frame.

Reset
REQ-027 rst=1 SHALL force: slot count 0, idx 0, state BLANK (SHOW if BLANK_CYCLES=0), staging/active 0, pending 0.
REQ-028 Output values in the cycle after rst: AN all ones, HEX 0, point 0, LE 0, frame_done 0.
REQ-029 rst mid-frame SHALL discard pending data and restart at digit 0 with no frame_done pulse.

Configuration
REQ-030 Macro LEADING_ZERO_BLANK_EN defined: digit k>0 SHALL keep AN[k]=1 when active nibbles k..DIGITS-1 are all 0 and active points k..DIGITS-1 are all 0; digit 0 follows REQ-020.
REQ-031 Macro undefined: no leading-zero suppression; AN per REQ-020 only.

Verification (DIGITS=4, DIV_W=4, BLANK_CYCLES=2)
REQ-032 rst 3 cycles, then idle -> AN=4'hF, HEX=0 until an update; frame_done every 64 cycles.
REQ-033 update hexs=16'h1234, LEs=4'hF -> after next boundary, per slot 2 cycles AN=F, then 14 cycles AN=E/D/B/7 with HEX=4/3/2/1.
REQ-034 update mid-frame with 16'hABCD while 16'h1234 shown -> remaining digits still show 1234; ABCD from next frame_done.
REQ-035 update asserted exactly on boundary cycle with 16'h5678 -> first slot of new frame HEX=8.
REQ-036 LEs=4'b1010 -> AN never low for digits 0 and 2; HEX still cycles.
REQ-037 LEADING_ZERO_BLANK_EN, hexs=16'h0050, points=0, LEs=F -> digits 2,3 AN stay 1, digit 0 shows 0, digit 1 shows 5; undefined -> all four light.
